g_4arb: RTL and testbench



---
 rtl/g_4arb.sv | 150 +++++++++++++++
 tb/tb_g_4arb.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/g_4arb.sv
// g_4arb: four-requester round-robin arbiter with registered one-hot grants, owner index and busy flag.
// Optional hold-time limit compiled in with `define G_4ARB_TIMEOUT_EN (HOLD cycles per grant).
module g_4arb #(
    parameter int HOLD = 16
) (
    input  logic       CK,
    input  logic       CDN,
    input  logic       AN,
    input  logic       BN,
    input  logic       C,
    input  logic       D,
    output logic       GA,
    output logic       GB,
    output logic       GC,
    output logic       GD,
    output logic [1:0] ID,
    output logic       Y
);

    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_GRANT   = 2'b01;
    localparam logic [1:0] S_RECOVER = 2'b10;

    if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
        $error("g_4arb: HOLD must be in 1..255");
    end

    logic [1:0] state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] id_q, id_d;
    logic [1:0] last_q, last_d;
    logic       y_q, y_d;

    logic [3:0] req_vec;
    logic [3:0] rot_req;
    logic       any_req;
    logic       owner_req;
    logic       timeout;
    logic       release_now;
    logic [1:0] pick_off;
    logic [1:0] winner;

    // Mixed-polarity inputs folded into one active-high vector, index 3..0 = D, C, B, A.
    assign req_vec     = {D, C, ~BN, ~AN};
    assign any_req     = |req_vec;
    assign owner_req   = req_vec[id_q];
    assign release_now = ~owner_req | timeout;

    // Requests rotated so bit 0 is the requester just after the previous owner.
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
        assign rot_req[gi] = req_vec[last_q + 2'(gi + 1)];
    end

    always_comb begin
        pick_off = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rot_req[i]) begin
                pick_off = 2'(i);
            end
        end
        winner = last_q + 2'd1 + pick_off;
    end

`ifdef G_4ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;

    assign timeout = (hold_q == 8'(HOLD - 1));
`else
    assign timeout = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge CK or negedge CDN) begin
        if (!CDN) begin
            state_q <= S_IDLE;
            grant_q <= 4'b0000;
            id_q    <= 2'd0;
            last_q  <= 2'd3;
            y_q     <= 1'b0;
`ifdef G_4ARB_TIMEOUT_EN
            hold_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            last_q  <= last_d;
            y_q     <= y_d;
`ifdef G_4ARB_TIMEOUT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:    state_d = any_req ? S_GRANT : S_IDLE;
            S_GRANT:   state_d = release_now ? S_RECOVER : S_GRANT;
            S_RECOVER: state_d = any_req ? S_GRANT : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        grant_d = 4'b0000;
        id_d    = id_q;
        last_d  = last_q;
`ifdef G_4ARB_TIMEOUT_EN
        hold_d  = hold_q;
`endif
        case (state_q)
            S_IDLE, S_RECOVER: begin
                if (any_req) begin
                    grant_d = 4'b0001 << winner;
                    id_d    = winner;
`ifdef G_4ARB_TIMEOUT_EN
                    hold_d  = 8'd0;
`endif
                end
            end
            S_GRANT: begin
                if (release_now) begin
                    last_d = id_q;
                end else begin
                    grant_d = grant_q;
`ifdef G_4ARB_TIMEOUT_EN
                    if (hold_q != 8'd255) begin
                        hold_d = hold_q + 8'd1;
                    end
`endif
                end
            end
            default: begin
                grant_d = 4'b0000;
            end
        endcase
        y_d = |grant_d;
    end

    assign GA = grant_q[0];
    assign GB = grant_q[1];
    assign GC = grant_q[2];
    assign GD = grant_q[3];
    assign ID = id_q;
    assign Y  = y_q;

endmodule

// File: tb/tb_g_4arb.sv
// Randomized scoreboard bench for g_4arb: a behavioural owner/last model predicts each edge's outputs.
// Build with or without `define G_4ARB_TIMEOUT_EN; the model follows the same macro.
module tb_g_4arb;

    localparam int HOLD = 4;
`ifdef G_4ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       CK  = 1'b0;
    logic       CDN = 1'b0;
    logic       AN  = 1'b1;
    logic       BN  = 1'b1;
    logic       C   = 1'b0;
    logic       D   = 1'b0;
    logic       GA, GB, GC, GD, Y;
    logic [1:0] ID;

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] id;
        logic       y;
    } exp_t;

    exp_t exp_q[$];

    // Model: who owns the resource (-1 none), who owned it last, cycles held, reported index.
    int m_owner, m_last, m_hold, m_id;

    g_4arb #(.HOLD(HOLD)) dut (
        .CK(CK), .CDN(CDN), .AN(AN), .BN(BN), .C(C), .D(D),
        .GA(GA), .GB(GB), .GC(GC), .GD(GD), .ID(ID), .Y(Y)
    );

    always #5 CK = ~CK;

    task automatic model_reset();
        m_owner = -1;
        m_last  = 3;
        m_hold  = 0;
        m_id    = 0;
    endtask

    // One clock edge of the arbitration rules, given the active-high request set r.
    task automatic model_edge(input logic [3:0] r);
        if (m_owner >= 0) begin
            if (!r[m_owner] || (TO_EN && m_hold == HOLD - 1)) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (m_hold < 255) begin
                m_hold++;
            end
        end else if (r != 4'b0000) begin
            for (int k = 1; k <= 4; k++) begin
                if (m_owner < 0 && r[(m_last + k) % 4]) begin
                    m_owner = (m_last + k) % 4;
                end
            end
            m_id   = m_owner;
            m_hold = 0;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.g  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        e.id = 2'(m_id);
        e.y  = (m_owner >= 0);
        return e;
    endfunction

    task automatic drive(input logic an, input logic bn, input logic c, input logic d);
        @(posedge CK);
        #2;
        CDN = 1'b1;
        AN = an; BN = bn; C = c; D = d;
        model_edge({d, c, ~bn, ~an});
        exp_q.push_back(model_out());
    endtask

    task automatic check_reset_now(input string tag);
        checks++;
        if ({GD, GC, GB, GA} !== 4'b0000 || ID !== 2'd0 || Y !== 1'b0) begin
            failures++;
            $display("FAIL %s: got g=%b id=%0d y=%b, want g=0000 id=0 y=0", tag, {GD, GC, GB, GA}, ID, Y);
        end else begin
            $display("reset %s: g=%b id=%0d y=%b", tag, {GD, GC, GB, GA}, ID, Y);
        end
    endtask

    // Clear between edges, check outputs drop at once, release before the next edge.
    task automatic pulse_reset(input logic an, input logic bn, input logic c, input logic d);
        @(posedge CK);
        #2;
        CDN = 1'b0;
        model_reset();
        #1;
        check_reset_now("mid_cycle");
        #1;
        CDN = 1'b1;
        AN = an; BN = bn; C = c; D = d;
        model_edge({d, c, ~bn, ~an});
        exp_q.push_back(model_out());
    endtask

    // Monitor: compares the outputs after every edge that has a pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge CK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                txn++;
                if ({GD, GC, GB, GA} !== e.g || ID !== e.id || Y !== e.y) begin
                    failures++;
                    $display("FAIL edge%0d: got g=%b id=%0d y=%b, want g=%b id=%0d y=%b",
                             txn, {GD, GC, GB, GA}, ID, Y, e.g, e.id, e.y);
                end else begin
                    $display("edge%0d: g=%b id=%0d y=%b", txn, {GD, GC, GB, GA}, ID, Y);
                end
            end
        end
    end

    initial begin
        logic [3:0] r;
        model_reset();
        repeat (2) @(posedge CK);
        #1;
        check_reset_now("power_on");

        // Reset priority, then round robin with all requests held
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        repeat (14) drive(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0);

        // Sole requester D, dropped for one cycle then re-asserted
        repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (2) drive(1'b1, 1'b1, 1'b0, 1'b0);

        // Long hold of C with D also pending
        repeat (22) drive(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (6) drive(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (2) drive(1'b1, 1'b1, 1'b0, 1'b0);

        // Reset during a B grant, then B alone again
        repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);
        pulse_reset(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);

        // Random traffic: each request toggles with probability 1/4 per cycle
        r = 4'b0000;
        for (int n = 0; n < 800; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(3) == 0) r[b] = ~r[b];
            end
            if ($urandom_range(99) == 0) begin
                pulse_reset(~r[0], ~r[1], r[2], r[3]);
            end else begin
                drive(~r[0], ~r[1], r[2], r[3]);
            end
        end
        repeat (2) drive(1'b1, 1'b1, 1'b0, 1'b0);

        @(posedge CK);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
